// File: rtl/regfile_32x64.sv
// ============================================================================
// Module   : regfile_32x64
// Purpose  : 32 x 64-bit integer register file with XZR at index 31,
//            two combinational read ports and one clocked write port.
//            The REGFILE_BYPASS_EN macro adds a write-to-read bypass.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module regfile_mux8 #(
  parameter int W = 64
) (
  input  logic [2:0]        sel,
  input  logic [7:0][W-1:0] d,
  output logic [W-1:0]      y
);
  always_comb begin
    y = d[sel];
  end
endmodule

module regfile_mux4 #(
  parameter int W = 64
) (
  input  logic [1:0]        sel,
  input  logic [3:0][W-1:0] d,
  output logic [W-1:0]      y
);
  always_comb begin
    y = d[sel];
  end
endmodule

// 32:1 selection as four 8:1 leaves on addr[2:0] feeding one 4:1 on addr[4:3].
module regfile_read_tree #(
  parameter int DATA_W = 64
) (
  input  logic [4:0]                    addr,
  input  logic [31:0][DATA_W-1:0]       src,
  output logic [DATA_W-1:0]             data
);
  logic [3:0][DATA_W-1:0] leaf;

  for (genvar g = 0; g < 4; g++) begin : g_leaf
    regfile_mux8 #(.W(DATA_W)) u_mux8 (
      .sel (addr[2:0]),
      .d   (src[g*8 +: 8]),
      .y   (leaf[g])
    );
  end

  regfile_mux4 #(.W(DATA_W)) u_mux4 (
    .sel (addr[4:3]),
    .d   (leaf),
    .y   (data)
  );
endmodule

module regfile_32x64 #(
  parameter int DATA_W = 64,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);
  localparam int NSTORED = NREGS - 1;
  localparam logic [ADDR_W-1:0] XZR_IDX = ADDR_W'(NREGS - 1);

  logic [NSTORED-1:0]            wr_en;
  logic [NREGS-1:0][DATA_W-1:0]  rd_src;
  logic [DATA_W-1:0]             tree1;
  logic [DATA_W-1:0]             tree2;

  // One-hot decode gated by RegWrite; index 31 has no enable at all, so
  // unknown address bits cannot reach any storage while RegWrite is low.
  always_comb begin
    wr_en = '0;
    for (int i = 0; i < NSTORED; i++) begin
      wr_en[i] = RegWrite && (WriteRegister == ADDR_W'(i));
    end
  end

  for (genvar r = 0; r < NSTORED; r++) begin : g_reg
    logic [DATA_W-1:0] reg_d;
    logic [DATA_W-1:0] reg_q;

    always_comb begin
      reg_d = reg_q;
      if (wr_en[r]) begin
        reg_d = WriteData;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign rd_src[r] = reg_q;
  end

  assign rd_src[NREGS-1] = '0;

  regfile_read_tree #(.DATA_W(DATA_W)) u_rd1 (
    .addr (ReadRegister1),
    .src  (rd_src),
    .data (tree1)
  );

  regfile_read_tree #(.DATA_W(DATA_W)) u_rd2 (
    .addr (ReadRegister2),
    .src  (rd_src),
    .data (tree2)
  );

`ifdef REGFILE_BYPASS_EN
  logic byp1;
  logic byp2;

  // Reset must win over the bypass since WriteData is not cleared by reset.
  always_comb begin
    byp1 = RegWrite && (WriteRegister != XZR_IDX) && (ReadRegister1 == WriteRegister);
    byp2 = RegWrite && (WriteRegister != XZR_IDX) && (ReadRegister2 == WriteRegister);
    if (!reset_n) begin
      ReadData1 = '0;
      ReadData2 = '0;
    end else begin
      ReadData1 = byp1 ? WriteData : tree1;
      ReadData2 = byp2 ? WriteData : tree2;
    end
  end
`else
  logic unused_xzr;
  assign unused_xzr = ^XZR_IDX;
  assign ReadData1  = tree1;
  assign ReadData2  = tree2;
`endif

endmodule

`default_nettype wire
